tally_scheduler: RTL

Round-robin scheduler that shares one 6-bit popcount (tally) unit among NREQ requesters in the Huffman accelerator front end. Each requester streams a job of 6-bit words terminated by a last flag. The scheduler grants one job at a time and feeds each accepted word to the tally unit, which sits outside this block. It accumulates the per-word ones counts and returns the job total tagged with the requester ID.

---
 rtl/tally_scheduler_if.sv | 30 +++
 rtl/tally_scheduler.sv | 103 ++++++++++
 2 files changed

// File: rtl/tally_scheduler_if.sv
// Requester, tally-unit and result signals of the tally scheduler.
// master = requesters/tally unit/result consumer side, slave = scheduler.
interface tally_scheduler_if #(
    parameter int NREQ  = 4,
    parameter int ACC_W = 16
);
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]   req_valid;
    logic [NREQ*6-1:0] req_data;
    logic [NREQ-1:0]   req_last;
    logic [NREQ-1:0]   req_ready;
    logic [5:0]        tal_in;
    logic [7:0]        tal_out;
    logic              res_valid;
    logic [ACC_W-1:0]  res_data;
    logic [IDW-1:0]    res_id;
    logic              res_sat;
    logic              res_ready;

    modport master (
        output req_valid, req_data, req_last, tal_out, res_ready,
        input  req_ready, tal_in, res_valid, res_data, res_id, res_sat
    );

    modport slave (
        input  req_valid, req_data, req_last, tal_out, res_ready,
        output req_ready, tal_in, res_valid, res_data, res_id, res_sat
    );
endinterface

// File: rtl/tally_scheduler.sv
// Round-robin share of one popcount unit across NREQ word streams; sums each job's ones counts.
// Grant 1 cycle after valid, 1 word/cycle, result next cycle; stalls on req_valid low, holds result until res_ready.
module tally_scheduler #(
    parameter int NREQ  = 4,
    parameter int ACC_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    tally_scheduler_if.slave  bus
);
    localparam int IDW = $clog2(NREQ);
    // Sum width covers both operands plus a carry, since ACC_W may be narrower than tal_out.
    localparam int SW  = ((ACC_W > 8) ? ACC_W : 8) + 1;
    localparam logic [SW-1:0] MAXV = {{(SW-ACC_W){1'b0}}, {ACC_W{1'b1}}};

    typedef enum logic [1:0] {IDLE, RUN, RESULT} state_t;

    state_t           state, state_nxt;
    logic [IDW-1:0]   gnt, prio_ptr, pick, idx_l;
    logic [ACC_W-1:0] acc, acc_nxt;
    logic             sat, ovf, found;
    logic             beat, last_beat, any_vld;
    logic [SW-1:0]    sum;
    int               idx;

    assign any_vld   = |bus.req_valid;
    assign beat      = (state == RUN) && bus.req_valid[gnt];
    assign last_beat = beat && bus.req_last[gnt];
    assign sum       = SW'(acc) + SW'(bus.tal_out);
    assign ovf       = (sum > MAXV);
    assign acc_nxt   = ovf ? {ACC_W{1'b1}} : sum[ACC_W-1:0];

    // First valid requester at or above prio_ptr, wrapping.
    always_comb begin
        pick  = prio_ptr;
        found = 1'b0;
        idx   = 0;
        idx_l = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx   = (int'(prio_ptr) + i) % NREQ;
            idx_l = IDW'(idx);
            if (!found && bus.req_valid[idx_l]) begin
                pick  = idx_l;
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_vld)       state_nxt = RUN;
            RUN:     if (last_beat)     state_nxt = RESULT;
            RESULT:  if (bus.res_ready) state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready = '0;
        bus.tal_in    = '0;
        bus.res_valid = 1'b0;
        bus.res_data  = '0;
        bus.res_id    = '0;
        bus.res_sat   = 1'b0;
        case (state)
            RUN: begin
                bus.req_ready[gnt] = 1'b1;
                bus.tal_in         = bus.req_data[6*gnt +: 6];
            end
            RESULT: begin
                bus.res_valid = 1'b1;
                bus.res_data  = acc;
                bus.res_id    = gnt;
                bus.res_sat   = sat;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt      <= '0;
            prio_ptr <= '0;
            acc      <= '0;
            sat      <= 1'b0;
        end else if (state == IDLE && any_vld) begin
            gnt <= pick;
            acc <= '0;
            sat <= 1'b0;
        end else if (beat) begin
            acc <= acc_nxt;
            sat <= sat | ovf;
            if (bus.req_last[gnt])
                prio_ptr <= (gnt == IDW'(NREQ-1)) ? '0 : gnt + IDW'(1);
        end
    end
endmodule
